image_ycbcr444_ycbcr422: RTL and testbench
==========================================

Name: image_ycbcr444_ycbcr422

Overview:
Stage directly downstream of the RGB888→YCbCr444 converter in the video pipeline. Converts a 4:4:4 YCbCr pixel stream to a 4:2:2 stream carrying Y plus one alternating chroma sample per pixel, in Y0/Cb, Y1/Cr order. Chroma is either averaged over each horizontal pixel pair or co-sited from the even pixel. It forwards vsync/href/clken with matched latency for the next stage: packer, VDMA writer or simulation dump.

Parameters:
AVG_EN, 1, 1 = chroma of each pair is the rounded average of both pixels; 0 = chroma taken from the even pixel only (co-sited).
CB_FIRST, 1, 1 = even pixel of a pair carries Cb and odd pixel carries Cr; 0 = swapped.

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
per_frame_vsync  in  1  input frame vsync
per_frame_href  in  1  input line valid
per_frame_clken  in  1  input pixel enable; must equal href inside active lines (contiguous pixels)
per_img_Y  in  8  input luma
per_img_Cb  in  8  input blue chroma
per_img_Cr  in  8  input red chroma
post_frame_vsync  out  1  vsync delayed 2 clocks
post_frame_href  out  1  href delayed 2 clocks
post_frame_clken  out  1  clken delayed 2 clocks
post_img_Y  out  8  luma, 0 when post_frame_href=0
post_img_C  out  8  alternating Cb/Cr, 0 when post_frame_href=0

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low (rst_n). Every register clears to 0, so all outputs read 0 during reset. The phase bit clears to even.
- Latency is fixed at 2 clocks for data and for all three sync signals. Throughput is 1 pixel/clock.
- Stage 1 registers the input pixel (Y_d, Cb_d, Cr_d, valid_d = href&clken) and holds the previous pixel's Cb/Cr (Cb_p, Cr_p).
- Phase bit: toggles on every valid input pixel and is forced to 0 in any cycle where per_frame_href=0. The first pixel of every line is therefore even.
- Stage 2, with valid_d=1 and phase of the pixel in stage 1:
  - Even pixel, AVG_EN=1: if a valid input pixel is present the same cycle (the partner), C = (first_chroma_d + first_chroma_in + 1) >> 1. Otherwise (odd line width, last pixel) C = first_chroma_d, unaveraged.
  - Odd pixel, AVG_EN=1: C = (second_chroma_p + second_chroma_d + 1) >> 1.
  - AVG_EN=0: even pixel gives C = first_chroma_d; odd pixel gives C = second_chroma_p (even pixel's value).
  - first_chroma is Cb when CB_FIRST=1, else Cr. second_chroma is the other one.
- Arithmetic: sums are 9-bit unsigned, +1 rounds half-up, result is bits [8:1]. Overflow is impossible (max (255+255+1)>>1 = 255).
- Y passes through unmodified in 2 clocks.
- Output gating: post_img_Y/post_img_C are forced to 8'd0 whenever post_frame_href=0.
- Line boundary: pairing never spans lines. The phase reset on href low guarantees this even with a single-cycle blanking gap.
- Reset mid-line: outputs go to 0 immediately (asynchronous). After release, the first valid pixel is treated as even. Partial pairs from before reset are discarded.
- vsync has no effect on pairing; it is only delayed.
- clken gaps inside href are unsupported; behaviour then is undefined except that sync signals remain delayed by exactly 2.

Test Plan:
- AVG_EN=1, CB_FIRST=1, line of 2 pixels (Y10,Cb100,Cr200),(Y20,Cb103,Cr50) at cycles t,t+1 → t+2: Y=10,C=102; t+3: Y=20,C=125; href_out high t+2..t+3 only.
- Odd width: 3-pixel line, third pixel (Y30,Cb77,Cr9) → third output Y=30,C=77, unaveraged; next line's first pixel again outputs averaged Cb.
- AVG_EN=0 with the same pair as the first scenario → C=100 then C=200; CB_FIRST=0 → C=200 then C=100.
- Extremes: pair Cb 255/255, Cr 0/1 → C=255 then C=1 (rounding up); pair Cb 0/1 → 1.
- Back-to-back lines with 1-cycle href gap, 4 pixels each → each line starts with Cb; no chroma mixing across lines; outputs 0 in the gap.
- Assert rst_n low mid-line after pixel 1 → all outputs 0 the same cycle; after release a new line pairs from its first pixel; vsync/href/clken out match inputs delayed by 2.

Source files
------------

// File: rtl/image_ycbcr444_ycbcr422.sv
// image_ycbcr444_ycbcr422: YCbCr 4:4:4 to 4:2:2 (Y0/C0, Y1/C1) with optional chroma pair averaging.
// Two-stage pipeline; sync signals are delayed to match the data path.
module image_ycbcr444_ycbcr422 #(
  parameter bit AVG_EN   = 1'b1,
  parameter bit CB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  input  logic [7:0] per_img_Cb,
  input  logic [7:0] per_img_Cr,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_Y,
  output logic [7:0] post_img_C
);
  logic [1:0] vsync_r, href_r, clken_r;
  logic [7:0] y_d, cb_d, cr_d, cb_p, cr_p, y_q, c_q;
  logic       valid_d, phase, phase_d, in_valid;
  logic [7:0] f_in, f_d, s_d, s_p, c_nxt;
  logic [8:0] sum_even, sum_odd;
  assign in_valid = per_frame_href & per_frame_clken;
  assign f_in     = CB_FIRST ? per_img_Cb : per_img_Cr;
  assign f_d      = CB_FIRST ? cb_d : cr_d;
  assign s_d      = CB_FIRST ? cr_d : cb_d;
  assign s_p      = CB_FIRST ? cr_p : cb_p;
  assign sum_even = {1'b0, f_d} + {1'b0, f_in} + 9'd1;
  assign sum_odd  = {1'b0, s_p} + {1'b0, s_d} + 9'd1;
  // An even pixel without a partner behind it closes an odd-width line: pass its chroma unaveraged.
  always_comb begin
    c_nxt = 8'd0;
    if (valid_d)
      c_nxt = !phase_d ? ((AVG_EN && in_valid) ? sum_even[8:1] : f_d)
                       : (AVG_EN ? sum_odd[8:1] : s_p);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r <= '0;
      href_r  <= '0;
      clken_r <= '0;
      y_d     <= '0;
      cb_d    <= '0;
      cr_d    <= '0;
      cb_p    <= '0;
      cr_p    <= '0;
      valid_d <= 1'b0;
      phase   <= 1'b0;
      phase_d <= 1'b0;
      y_q     <= '0;
      c_q     <= '0;
    end else begin
      vsync_r <= {vsync_r[0], per_frame_vsync};
      href_r  <= {href_r[0], per_frame_href};
      clken_r <= {clken_r[0], per_frame_clken};
      y_d     <= per_img_Y;
      cb_d    <= per_img_Cb;
      cr_d    <= per_img_Cr;
      cb_p    <= cb_d;
      cr_p    <= cr_d;
      valid_d <= in_valid;
      phase_d <= phase;
      phase   <= per_frame_href ? (phase ^ in_valid) : 1'b0;
      y_q     <= valid_d ? y_d : 8'd0;
      c_q     <= c_nxt;
    end
  end
  assign post_frame_vsync = vsync_r[1];
  assign post_frame_href  = href_r[1];
  assign post_frame_clken = clken_r[1];
  assign post_img_Y       = post_frame_href ? y_q : 8'd0;
  assign post_img_C       = post_frame_href ? c_q : 8'd0;
endmodule

// File: tb/tb_image_ycbcr444_ycbcr422.sv
// tb_image_ycbcr444_ycbcr422: directed bench over all four AVG_EN/CB_FIRST variants.
// DUT index: 0 = avg/Cb first, 1 = co-sited/Cb first, 2 = co-sited/Cr first, 3 = avg/Cr first.
module tb_image_ycbcr444_ycbcr422;
  logic       clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, href = 1'b0, clken = 1'b0;
  logic [7:0] y = '0, cb = '0, cr = '0;
  logic [7:0] oy [4];
  logic [7:0] oc [4];
  logic       oh [4];
  logic       ov [4];
  logic       oe [4];
  int pass = 0, total = 0;
  logic       sh [32];
  logic       sv [32];
  logic [7:0] sy [32];
  logic [7:0] scb [32];
  logic [7:0] scr [32];
  logic [7:0] cy [32][4];
  logic [7:0] cc [32][4];
  logic       ch [32][4];
  logic       cv [32][4];
  logic       ce [32][4];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    image_ycbcr444_ycbcr422 #(.AVG_EN(g == 0 || g == 3), .CB_FIRST(g < 2)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
      .per_img_Y(y), .per_img_Cb(cb), .per_img_Cr(cr),
      .post_frame_vsync(ov[g]), .post_frame_href(oh[g]), .post_frame_clken(oe[g]),
      .post_img_Y(oy[g]), .post_img_C(oc[g])
    );
  end
  task automatic drive(input logic h, input logic v, input logic [7:0] yy, input logic [7:0] b, input logic [7:0] r);
    href = h; clken = h; vsync = v; y = yy; cb = b; cr = r;
  endtask
  task automatic vec(input int i, input logic h, input logic v, input logic [7:0] yy, input logic [7:0] b, input logic [7:0] r);
    sh[i] = h; sv[i] = v; sy[i] = yy; scb[i] = b; scr[i] = r;
  endtask
  // Output observed two negedges after a vector is applied belongs to that vector.
  task automatic play(input int n);
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (k >= 2)
        for (int d = 0; d < 4; d++) begin
          cy[k-2][d] = oy[d]; cc[k-2][d] = oc[d]; ch[k-2][d] = oh[d]; cv[k-2][d] = ov[d]; ce[k-2][d] = oe[d];
        end
      if (k < n) drive(sh[k], sv[k], sy[k], scb[k], scr[k]);
      else drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 8'd99, 8'd98, 8'd97);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      total++;
      if (oy[d] !== 8'd0 || oc[d] !== 8'd0 || oh[d] !== 1'b0 || ov[d] !== 1'b0 || oe[d] !== 1'b0)
        $display("FAIL reset dut%0d: Y=%0d C=%0d href=%b vsync=%b clken=%b, expected all 0", d, oy[d], oc[d], oh[d], ov[d], oe[d]);
      else pass++;
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_pair;
    logic [7:0] ey [3] = '{10, 20, 0};
    logic [7:0] ec [4][3] = '{'{102, 125, 0}, '{100, 200, 0}, '{200, 100, 0}, '{125, 102, 0}};
    logic [2:0] eh = 3'b011, ev = 3'b000;
    vec(0, 1, 0, 10, 100, 200); vec(1, 1, 0, 20, 103, 50); vec(2, 0, 0, 0, 0, 0);
    play(3);
    for (int j = 0; j < 3; j++)
      for (int d = 0; d < 4; d++) begin
        total++;
        if (cy[j][d] !== ey[j] || cc[j][d] !== ec[d][j] || ch[j][d] !== eh[j] || ce[j][d] !== eh[j] || cv[j][d] !== ev[j])
          $display("FAIL pair[%0d] dut%0d: Y=%0d C=%0d href=%b clken=%b vsync=%b, expected Y=%0d C=%0d href=%b vsync=%b",
                   j, d, cy[j][d], cc[j][d], ch[j][d], ce[j][d], cv[j][d], ey[j], ec[d][j], eh[j], ev[j]);
        else pass++;
      end
  endtask
  task automatic test_odd_width;
    logic [7:0] ey [7] = '{10, 20, 30, 0, 40, 50, 0};
    logic [7:0] ec [4][7] = '{'{102, 125, 77, 0, 65, 2, 0}, '{100, 200, 77, 0, 60, 1, 0},
                              '{200, 100, 9, 0, 1, 60, 0},  '{125, 102, 9, 0, 2, 65, 0}};
    logic [6:0] eh = 7'b0110111, ev = 7'b0;
    vec(0, 1, 0, 10, 100, 200); vec(1, 1, 0, 20, 103, 50); vec(2, 1, 0, 30, 77, 9); vec(3, 0, 0, 0, 0, 0);
    vec(4, 1, 0, 40, 60, 1);    vec(5, 1, 0, 50, 70, 3);   vec(6, 0, 0, 0, 0, 0);
    play(7);
    for (int j = 0; j < 7; j++)
      for (int d = 0; d < 4; d++) begin
        total++;
        if (cy[j][d] !== ey[j] || cc[j][d] !== ec[d][j] || ch[j][d] !== eh[j] || ce[j][d] !== eh[j] || cv[j][d] !== ev[j])
          $display("FAIL odd_width[%0d] dut%0d: Y=%0d C=%0d href=%b clken=%b vsync=%b, expected Y=%0d C=%0d href=%b vsync=%b",
                   j, d, cy[j][d], cc[j][d], ch[j][d], ce[j][d], cv[j][d], ey[j], ec[d][j], eh[j], ev[j]);
        else pass++;
      end
  endtask
  task automatic test_extremes;
    logic [7:0] ey [6] = '{1, 2, 0, 3, 4, 0};
    logic [7:0] ec [4][6] = '{'{255, 1, 0, 1, 0, 0}, '{255, 0, 0, 0, 0, 0},
                              '{0, 255, 0, 0, 0, 0}, '{1, 255, 0, 0, 1, 0}};
    logic [5:0] eh = 6'b011011, ev = 6'b0;
    vec(0, 1, 0, 1, 255, 0); vec(1, 1, 0, 2, 255, 1); vec(2, 0, 0, 0, 0, 0);
    vec(3, 1, 0, 3, 0, 0);   vec(4, 1, 0, 4, 1, 0);   vec(5, 0, 0, 0, 0, 0);
    play(6);
    for (int j = 0; j < 6; j++)
      for (int d = 0; d < 4; d++) begin
        total++;
        if (cy[j][d] !== ey[j] || cc[j][d] !== ec[d][j] || ch[j][d] !== eh[j] || ce[j][d] !== eh[j] || cv[j][d] !== ev[j])
          $display("FAIL extremes[%0d] dut%0d: Y=%0d C=%0d href=%b clken=%b vsync=%b, expected Y=%0d C=%0d href=%b vsync=%b",
                   j, d, cy[j][d], cc[j][d], ch[j][d], ce[j][d], cv[j][d], ey[j], ec[d][j], eh[j], ev[j]);
        else pass++;
      end
  endtask
  task automatic test_back_to_back;
    logic [7:0] ey [9] = '{1, 2, 3, 0, 5, 6, 7, 8, 0};
    logic [7:0] ec [4][9] = '{'{20, 30, 50, 0, 201, 102, 2, 251, 0}, '{10, 20, 50, 0, 200, 100, 0, 250, 0},
                              '{20, 10, 60, 0, 100, 200, 250, 0, 0}, '{30, 20, 60, 0, 102, 201, 251, 2, 0}};
    logic [8:0] eh = 9'b011110111, ev = 9'b100001000;
    vec(0, 1, 0, 1, 10, 20);   vec(1, 1, 0, 2, 30, 40);   vec(2, 1, 0, 3, 50, 60);  vec(3, 0, 1, 0, 0, 0);
    vec(4, 1, 0, 5, 200, 100); vec(5, 1, 0, 6, 202, 104); vec(6, 1, 0, 7, 0, 250); vec(7, 1, 0, 8, 3, 252);
    vec(8, 0, 1, 0, 0, 0);
    play(9);
    for (int j = 0; j < 9; j++)
      for (int d = 0; d < 4; d++) begin
        total++;
        if (cy[j][d] !== ey[j] || cc[j][d] !== ec[d][j] || ch[j][d] !== eh[j] || ce[j][d] !== eh[j] || cv[j][d] !== ev[j])
          $display("FAIL back_to_back[%0d] dut%0d: Y=%0d C=%0d href=%b clken=%b vsync=%b, expected Y=%0d C=%0d href=%b vsync=%b",
                   j, d, cy[j][d], cc[j][d], ch[j][d], ce[j][d], cv[j][d], ey[j], ec[d][j], eh[j], ev[j]);
        else pass++;
      end
  endtask
  task automatic test_mid_line_reset;
    logic [7:0] e0 [4] = '{41, 40, 80, 82};
    logic [7:0] eq [2][4] = '{'{15, 10, 0, 1}, '{1, 0, 10, 15}};
    @(negedge clk); drive(1'b1, 1'b1, 8'd11, 8'd40, 8'd80);
    @(negedge clk); drive(1'b1, 1'b1, 8'd12, 8'd42, 8'd84);
    @(negedge clk); drive(1'b1, 1'b1, 8'd13, 8'd44, 8'd88);
    for (int d = 0; d < 4; d++) begin
      total++;
      if (oy[d] !== 8'd11 || oc[d] !== e0[d] || oh[d] !== 1'b1 || ov[d] !== 1'b1 || oe[d] !== 1'b1)
        $display("FAIL pre_reset dut%0d: Y=%0d C=%0d href=%b vsync=%b clken=%b, expected Y=11 C=%0d href=1 vsync=1 clken=1",
                 d, oy[d], oc[d], oh[d], ov[d], oe[d], e0[d]);
      else pass++;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      total++;
      if (oy[d] !== 8'd0 || oc[d] !== 8'd0 || oh[d] !== 1'b0 || ov[d] !== 1'b0 || oe[d] !== 1'b0)
        $display("FAIL async_reset dut%0d: Y=%0d C=%0d href=%b vsync=%b clken=%b, expected all 0", d, oy[d], oc[d], oh[d], ov[d], oe[d]);
      else pass++;
    end
    @(negedge clk); rst_n = 1'b1; drive(1'b1, 1'b0, 8'd21, 8'd10, 8'd0);
    @(negedge clk); drive(1'b1, 1'b0, 8'd22, 8'd20, 8'd2);
    @(negedge clk); drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int j = 0; j < 3; j++) begin
      for (int d = 0; d < 4; d++) begin
        total++;
        if (j < 2 && (oy[d] !== 8'(21 + j) || oc[d] !== eq[j][d] || oh[d] !== 1'b1 || oe[d] !== 1'b1 || ov[d] !== 1'b0))
          $display("FAIL after_reset[%0d] dut%0d: Y=%0d C=%0d href=%b clken=%b vsync=%b, expected Y=%0d C=%0d href=1 clken=1 vsync=0",
                   j, d, oy[d], oc[d], oh[d], oe[d], ov[d], 21 + j, eq[j][d]);
        else if (j == 2 && (oy[d] !== 8'd0 || oc[d] !== 8'd0 || oh[d] !== 1'b0 || oe[d] !== 1'b0))
          $display("FAIL after_reset_idle dut%0d: Y=%0d C=%0d href=%b clken=%b, expected all 0", d, oy[d], oc[d], oh[d], oe[d]);
        else pass++;
      end
      @(negedge clk);
    end
  endtask
  initial begin
    test_reset;
    test_pair;
    test_odd_width;
    test_extremes;
    test_back_to_back;
    test_mid_line_reset;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
